// File: rtl/response_packetizer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : response_packetizer
//  Description : Turns one response descriptor (opcode, 32-bit word, byte
//                count) into a UART byte packet:
//                  opcode, RSVD_BYTE, 4+len, 8'h00, payload[len] LSB-first.
//  Ports       : clk_i, rst_i           clock / synchronous active-high reset
//                req_valid_i/req_ready_o descriptor handshake
//                req_opcode_i/req_data_i/req_len_i descriptor fields
//                tx_data_o/tx_valid_o/tx_ready_i byte stream to uart_tx
//                busy_o                  packet in flight
//                pkt_count_o             packets completed since reset
//  Revision    : 1.0  initial release
// ============================================================================
module response_packetizer #(
    parameter logic [7:0] RSVD_BYTE = 8'h00
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [7:0]  req_opcode_i,
    input  logic [31:0] req_data_i,
    input  logic [2:0]  req_len_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        busy_o,
    output logic [15:0] pkt_count_o
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_HDR  = 2'd1;
    localparam logic [1:0] c_ST_PAY  = 2'd2;

    logic [1:0]  r_state;
    logic [7:0]  r_opcode;
    logic [31:0] r_data;
    logic [2:0]  r_len;
    logic [2:0]  r_idx;       // index of the byte currently presented
    logic [7:0]  r_tx_data;
    logic        r_tx_valid;
    logic [15:0] r_pkt_count;

    logic [1:0]  w_state_nxt;
    logic [2:0]  w_idx_nxt;
    logic [7:0]  w_tx_data_nxt;
    logic        w_tx_valid_nxt;
    logic        w_cnt_inc;
    logic        w_accept;
    logic        w_hs;
    logic [2:0]  w_idx_inc;
    logic [2:0]  w_len_clamp;
    logic [7:0]  w_hdr_next;
    logic [7:0]  w_pay_next;

    assign w_hs        = r_tx_valid & tx_ready_i;
    assign w_idx_inc   = r_idx + 3'd1;
    assign w_len_clamp = (req_len_i > 3'd4) ? 3'd4 : req_len_i;
    assign w_pay_next  = r_data[{w_idx_inc[1:0], 3'b000} +: 8];

    // Header byte that follows the one currently on the bus (idx 1..3).
    always_comb begin
        w_hdr_next = 8'h00;
        case (w_idx_inc)
            3'd1:    w_hdr_next = RSVD_BYTE;
            3'd2:    w_hdr_next = 8'd4 + {5'd0, r_len};
            default: w_hdr_next = 8'h00;
        endcase
    end

    // Next-state logic; the outgoing byte is computed one cycle ahead so that
    // tx_data_o/tx_valid_o come straight from flops with no bubbles.
    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_tx_data_nxt  = r_tx_data;
        w_tx_valid_nxt = r_tx_valid;
        w_cnt_inc      = 1'b0;
        w_accept       = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_tx_valid_nxt = 1'b0;
                w_tx_data_nxt  = 8'h00;
                if (req_valid_i) begin
                    w_accept       = 1'b1;
                    w_state_nxt    = c_ST_HDR;
                    w_idx_nxt      = 3'd0;
                    w_tx_valid_nxt = 1'b1;
                    w_tx_data_nxt  = req_opcode_i;
                end
            end
            c_ST_HDR: begin
                if (w_hs) begin
                    if (r_idx == 3'd3) begin
                        if (r_len == 3'd0) begin
                            w_state_nxt    = c_ST_IDLE;
                            w_tx_valid_nxt = 1'b0;
                            w_tx_data_nxt  = 8'h00;
                            w_cnt_inc      = 1'b1;
                        end else begin
                            w_state_nxt   = c_ST_PAY;
                            w_idx_nxt     = 3'd0;
                            w_tx_data_nxt = r_data[7:0];
                        end
                    end else begin
                        w_idx_nxt     = w_idx_inc;
                        w_tx_data_nxt = w_hdr_next;
                    end
                end
            end
            c_ST_PAY: begin
                if (w_hs) begin
                    if (r_idx == (r_len - 3'd1)) begin
                        w_state_nxt    = c_ST_IDLE;
                        w_tx_valid_nxt = 1'b0;
                        w_tx_data_nxt  = 8'h00;
                        w_cnt_inc      = 1'b1;
                    end else begin
                        w_idx_nxt     = w_idx_inc;
                        w_tx_data_nxt = w_pay_next;
                    end
                end
            end
            default: begin
                w_state_nxt    = c_ST_IDLE;
                w_tx_valid_nxt = 1'b0;
                w_tx_data_nxt  = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= c_ST_IDLE;
            r_opcode    <= 8'h00;
            r_data      <= 32'h0;
            r_len       <= 3'd0;
            r_idx       <= 3'd0;
            r_tx_data   <= 8'h00;
            r_tx_valid  <= 1'b0;
            r_pkt_count <= 16'h0000;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_tx_data   <= w_tx_data_nxt;
            r_tx_valid  <= w_tx_valid_nxt;
            r_pkt_count <= r_pkt_count + {15'd0, w_cnt_inc};
            if (w_accept) begin
                r_opcode <= req_opcode_i;
                r_data   <= req_data_i;
                r_len    <= w_len_clamp;
            end
        end
    end

    // r_opcode is kept for visibility/debug; byte 0 is loaded directly at accept.
    logic w_unused;
    assign w_unused = ^r_opcode;

    assign req_ready_o = (r_state == c_ST_IDLE) & ~rst_i;
    assign busy_o      = (r_state != c_ST_IDLE);
    assign tx_data_o   = r_tx_data;
    assign tx_valid_o  = r_tx_valid;
    assign pkt_count_o = r_pkt_count;

endmodule
`default_nettype wire

// File: tb/tb_response_packetizer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_response_packetizer
//  Description : Self-checking bench for response_packetizer. Expected bytes
//                are queued when a descriptor is driven and compared as the
//                DUT hands them over.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_response_packetizer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_opcode;
    logic [31:0] req_data;
    logic [2:0]  req_len;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic [15:0] pkt_count;

    always #5 clk = ~clk;

    response_packetizer #(.RSVD_BYTE(8'h00)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_opcode_i(req_opcode),
        .req_data_i  (req_data),
        .req_len_i   (req_len),
        .tx_data_o   (tx_data),
        .tx_valid_o  (tx_valid),
        .tx_ready_i  (tx_ready),
        .busy_o      (busy),
        .pkt_count_o (pkt_count)
    );

    typedef struct {
        logic [7:0]  op;
        logic [31:0] data;
        logic [2:0]  len;
        int          nbytes;
        logic [63:0] exp;     // expected packet, byte 0 in bits [7:0]
    } vec_t;

    vec_t       vecs[7];
    logic [7:0] exp_q[$];
    int         total = 0;
    int         bad   = 0;
    int         hs_seen = 0;
    logic       p_stall = 1'b0;
    logic [7:0] p_data  = 8'h00;
    logic [7:0] e;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Stream monitor: scoreboard pop on every handshake, stall stability,
    // and zero data whenever the stream is idle.
    always @(negedge clk) begin
        if (!rst) begin
            if (!tx_valid) begin
                total++;
                if (tx_data !== 8'h00) begin
                    bad++;
                    $display("FAIL idle_data got=%h want=00", tx_data);
                end
            end
            if (p_stall) begin
                total++;
                if (tx_valid !== 1'b1 || tx_data !== p_data) begin
                    bad++;
                    $display("FAIL stall_hold got=%b/%h want=1/%h", tx_valid, tx_data, p_data);
                end
            end
            if (tx_valid && tx_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL extra_byte got=%h want=none", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    if (tx_data !== e) begin
                        bad++;
                        $display("FAIL byte got=%h want=%h", tx_data, e);
                    end
                end
                hs_seen++;
            end
            p_stall = tx_valid && !tx_ready;
            p_data  = tx_data;
        end else begin
            p_stall = 1'b0;
        end
    end

    // Send one packet; optionally stall stall_n cycles on byte stall_pos and
    // churn the descriptor inputs while the packet is in flight.
    task automatic run_pkt(input vec_t v, input int stall_pos, input int stall_n, input bit churn);
        int          vcyc;
        int          stalls;
        int          hs0;
        logic [15:0] base;
        bit          done;
        @(posedge clk); #1;
        req_valid  = 1'b1;
        req_opcode = v.op;
        req_data   = v.data;
        req_len    = v.len;
        tx_ready   = 1'b1;
        @(negedge clk); #1;
        chk("ready_pre_accept", {31'd0, req_ready}, 32'd1);
        base = pkt_count;
        hs0  = hs_seen;
        for (int i = 0; i < v.nbytes; i++) exp_q.push_back(v.exp[8*i +: 8]);
        vcyc   = 0;
        stalls = stall_n;
        done   = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(posedge clk); #1;
            req_valid = churn;
            if (churn) begin
                req_opcode = 8'($urandom);
                req_data   = $urandom;
                req_len    = 3'($urandom_range(0, 7));
            end
            tx_ready = 1'b1;
            if ((hs_seen - hs0) == stall_pos && stalls > 0) begin
                tx_ready = 1'b0;
                stalls--;
            end
            @(negedge clk); #1;
            if (c == 0) begin
                chk("first_valid", {31'd0, tx_valid}, 32'd1);
                chk("first_byte", {24'd0, tx_data}, {24'd0, v.op});
            end
            chk("ready_low_in_pkt", {31'd0, req_ready}, 32'd0);
            if (tx_valid) vcyc++;
            if ((hs_seen - hs0) == v.nbytes) done = 1'b1;
        end
        req_valid = 1'b0;
        if (!done) begin
            bad++; total++;
            $display("FAIL pkt_timeout got=%0d want=%0d", hs_seen - hs0, v.nbytes);
        end
        chk("duration", vcyc, v.nbytes + stall_n);
        @(posedge clk); #1;
        tx_ready = 1'b0;
        @(negedge clk); #1;
        chk("busy_after", {31'd0, busy}, 32'd0);
        chk("ready_after", {31'd0, req_ready}, 32'd1);
        chk("valid_after", {31'd0, tx_valid}, 32'd0);
        chk("count_after", {16'd0, pkt_count}, {16'd0, 16'(base + 16'd1)});
        chk("queue_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        int hs0;
        vecs[0] = '{8'hA0, 32'h12345678, 3'd4, 8, 64'h12345678_000800A0};
        vecs[1] = '{8'hEC, 32'hAABBCCDD, 3'd0, 4, 64'h00000000_000400EC};
        vecs[2] = '{8'hEC, 32'hAABBCCDD, 3'd1, 5, 64'h000000DD_000500EC};
        vecs[3] = '{8'hA1, 32'h00000006, 3'd7, 8, 64'h00000006_000800A1};
        vecs[4] = '{8'h33, 32'hAABBCCDD, 3'd2, 6, 64'h0000CCDD_00060033};
        vecs[5] = '{8'h5A, 32'h01020304, 3'd3, 7, 64'h00020304_0007005A};
        vecs[6] = '{8'hFF, 32'hCAFEBABE, 3'd5, 8, 64'hCAFEBABE_000800FF};

        rst = 1'b1; req_valid = 1'b0; req_opcode = 8'h00; req_data = 32'h0;
        req_len = 3'd0; tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_data", {24'd0, tx_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_count", {16'd0, pkt_count}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

        // Ready pulses while idle must not start anything.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            tx_ready = i[0];
        end
        @(negedge clk); #1;
        chk("idle_no_valid", {31'd0, tx_valid}, 32'd0);

        for (int k = 0; k < 7; k++) run_pkt(vecs[k], -1, 0, 1'b0);

        // Backpressure on header idx2, then on payload byte 2.
        run_pkt(vecs[0], 2, 3, 1'b0);
        run_pkt(vecs[0], 6, 3, 1'b0);

        // Descriptor churn while packets are in flight.
        run_pkt(vecs[5], -1, 0, 1'b1);
        run_pkt(vecs[2], 1, 2, 1'b1);
        run_pkt(vecs[1], -1, 0, 1'b1);

        // Reset right after the idx3 handshake.
        @(posedge clk); #1;
        req_valid = 1'b1; req_opcode = vecs[0].op; req_data = vecs[0].data;
        req_len = vecs[0].len; tx_ready = 1'b1;
        hs0 = hs_seen;
        for (int i = 0; i < vecs[0].nbytes; i++) exp_q.push_back(vecs[0].exp[8*i +: 8]);
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 0; c < 20 && (hs_seen - hs0) < 4; c++) begin
            @(negedge clk); #1;
        end
        chk("hdr_sent_before_rst", hs_seen - hs0, 32'd4);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); #1;
        chk("midrst_valid", {31'd0, tx_valid}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_count", {16'd0, pkt_count}, 32'd0);
        chk("midrst_ready", {31'd0, req_ready}, 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0; tx_ready = 1'b0;
        @(negedge clk); #1;
        chk("restart_ready", {31'd0, req_ready}, 32'd1);
        chk("restart_count", {16'd0, pkt_count}, 32'd0);
        run_pkt(vecs[4], -1, 0, 1'b0);

        // Counter wrap: preload 0xFFFF, then one header-only packet.
        @(posedge clk); #1;
        force dut.r_pkt_count = 16'hFFFF;
        @(negedge clk);
        release dut.r_pkt_count;
        #1;
        chk("preload", {16'd0, pkt_count}, 32'h0000FFFF);
        run_pkt(vecs[1], -1, 0, 1'b0);
        chk("wrap_zero", {16'd0, pkt_count}, 32'h00000000);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/response_packetizer.md
# response_packetizer

Serializes one ALU/echo response into a byte-stream packet for the UART transmitter; this is the transmit-side counterpart to the command parser. The block accepts a response descriptor (opcode, 32-bit payload word, payload byte count) over a valid/ready handshake. It emits the header plus payload bytes LSB-first over a byte-wide valid/ready stream into `uart_tx`. Packet layout matches the command framing: opcode, reserved, length LSB, length MSB, payload.

## Interface
- `RSVD_BYTE`, default `8'h00`: value sent in packet byte 1.
- `clk_i`  in  1  sole clock, all logic on posedge.
- `rst_i`  in  1  synchronous, active-high reset.
- `req_valid_i`  in  1  response descriptor valid.
- `req_ready_o`  out  1  block can accept a descriptor; high only in IDLE and not in reset.
- `req_opcode_i`  in  8  opcode echoed into byte 0.
- `req_data_i`  in  32  payload word, sent LSB-first.
- `req_len_i`  in  3  payload byte count; 0..4 legal, 5..7 clamped to 4.
- `tx_data_o`  out  8  byte to UART transmitter.
- `tx_valid_o`  out  1  `tx_data_o` valid.
- `tx_ready_i`  in  1  UART transmitter accepts the byte this cycle.
- `busy_o`  out  1  a packet is in flight (state != IDLE).
- `pkt_count_o`  out  16  packets fully sent since reset; wraps 0xFFFF -> 0x0000.

## Operation
- States:
  - IDLE: waits for a descriptor.
  - HDR: sends bytes 0-3.
  - PAY: sends payload bytes.
- **Accept.** Acceptance happens when `req_valid_i && req_ready_o`. In that cycle the block registers:
  - opcode and data;
  - `len = min(req_len_i, 4)`;
  - byte index 0.
  - The state then moves to HDR.
- **Header bytes:**
  - idx0 = opcode.
  - idx1 = `RSVD_BYTE`.
  - idx2 = total length `4 + len` (values 4..8).
  - idx3 = `8'h00`.
- **Payload.** Byte k (k = 0..len-1) = `data[8k+7:8k]`.
- **Advance rule.** The block advances to the next byte only on the handshake `tx_valid_o && tx_ready_i`.
- **HDR exit.** After the idx3 handshake:
  - if len == 0, go to IDLE;
  - otherwise go to PAY.
- **PAY exit.** After the handshake of payload byte len-1, go to IDLE and increment `pkt_count_o`. A header-only packet also increments `pkt_count_o` on its idx3 handshake.
- **Stream rule.** While `tx_valid_o` is high and `tx_ready_i` is low, `tx_data_o` and `tx_valid_o` hold stable. There are no bubbles between bytes when `tx_ready_i` is held high.
- **Descriptor inputs.** They are ignored outside the accept cycle. Changes to `req_*` mid-packet have no effect.
- **Registered outputs.** `tx_data_o`, `tx_valid_o` and `pkt_count_o` are registered. `req_ready_o` and `busy_o` decode directly from state, with `req_ready_o` forced low while `rst_i` is high.
- **Reset values:**
  - state IDLE;
  - `tx_valid_o` 0;
  - `tx_data_o` 0x00;
  - `busy_o` 0;
  - `pkt_count_o` 0;
  - `req_ready_o` 0 during reset and 1 in the first cycle after.
- **Reset mid-packet.** The packet is abandoned immediately:
  - `tx_valid_o` is 0 from the next edge;
  - no count increment;
  - no partial bytes are resumed.
- While `tx_valid_o` is 0, `tx_data_o` is 0x00.

## Timing
- Accept at edge N puts byte 0 on `tx_valid_o` in cycle N+1.
- With `tx_ready_i` held high, a packet occupies 4+len consecutive cycles, starting N+1.
- Last handshake at edge M gives IDLE, `req_ready_o` = 1 and the updated `pkt_count_o` in cycle M+1.
- The minimum gap between accepts is 4+len+1 cycles. Acceptance never overlaps the last byte.
- A stall of S cycles on any byte extends the packet by exactly S cycles.
- `tx_ready_i` is sampled only while `tx_valid_o` is high. A ready pulse while `tx_valid_o` is low has no effect.

## Test plan
- **Full 4-byte payload.**
  - Stimulus: opcode 0xA0, data 0x12345678, len 4, `tx_ready_i` = 1.
  - Response: bytes A0 00 08 00 78 56 34 12 on 8 consecutive cycles starting 1 cycle after accept; `pkt_count_o` 0 -> 1; `req_ready_o` high the cycle after byte 12.
- **Header-only and 1-byte payloads.**
  - len 0, opcode 0xEC: EC 00 04 00, then IDLE.
  - len 1, data 0xAABBCCDD: EC 00 05 00 DD.
- **Length clamp.**
  - Stimulus: len 7, opcode 0xA1, data 0x00000006.
  - Response: A1 00 08 00 06 00 00 00; exactly 8 bytes.
- **Backpressure.**
  - Stimulus: `tx_ready_i` low for 3 cycles while byte idx2 is presented, and in a second run low while payload byte 2 is presented.
  - Response: `tx_valid_o` stays 1 and `tx_data_o` stays at 0x08 (first run) or 0x34 (second run); no byte is skipped or duplicated; total duration is 8+3 cycles.
- **Reset mid-packet, then clean restart.**
  - Stimulus: assert `rst_i` after the handshake of idx3.
  - Response: `tx_valid_o` = 0 next cycle; `busy_o` = 0; `pkt_count_o` = 0. A fresh descriptor after reset produces a complete, correct packet.
- **Back-to-back, descriptor churn and counter wrap.**
  - Stimulus: `req_valid_i` held high with the descriptor changing every cycle.
  - Response: only the values present on accept cycles appear in packets; `req_ready_o` is low throughout each packet.
  - Wrap check: preload via 65535 header-only packets (or force), then send one more packet; `pkt_count_o` goes 0xFFFF -> 0x0000.
